// File: rtl/bcd_addsub_serial_if.sv
// Handshake and operand/result bus for the digit-serial BCD adder/subtractor.
interface bcd_addsub_serial_if #(parameter int N_DIGITS = 6);
  logic                       start;
  logic                       mode;
  logic [N_DIGITS-1:0][3:0]   a_in;
  logic [N_DIGITS-1:0][3:0]   b_in;
  logic                       busy;
  logic                       done;
  logic [N_DIGITS-1:0][3:0]   result;
  logic                       carry_out;
  logic                       err;

  modport master (output start, mode, a_in, b_in,
                  input  busy, done, result, carry_out, err);
  modport slave  (input  start, mode, a_in, b_in,
                  output busy, done, result, carry_out, err);
endinterface

// File: rtl/bcd_addsub_serial.sv
// Digit-serial BCD add/subtract, one digit per SUM(+CORR)/NEXT pass, LSD first.
// Optional input digit validity check: define BCD_DIGIT_CHECK_EN.
module bcd_addsub_serial #(
   parameter int N_DIGITS = 6
) (
   input  logic               clk,
   input  logic               rst,
   bcd_addsub_serial_if.slave bus
);
   localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_LOAD = 3'd1;
   localparam logic [2:0] S_SUM  = 3'd2;
   localparam logic [2:0] S_CORR = 3'd3;
   localparam logic [2:0] S_NEXT = 3'd4;
   localparam logic [2:0] S_DONE = 3'd5;

   logic [2:0]               state;
   logic [N_DIGITS-1:0][3:0] a_q, b_q, res_q, b_load;
   logic [IW-1:0]            idx;
   logic                     carry, carry_out_q, done_q;
   logic [4:0]               t;

   // Subtraction is A + nines(B) + 1; the +1 rides in on the initial carry.
   always_comb begin
      b_load = bus.b_in;
      for (int i = 0; i < N_DIGITS; i++)
         if (bus.mode) b_load[i] = 4'd9 - bus.b_in[i];
   end

   // Operands and carry are stable across SUM->CORR, so t needs no register.
   assign t = {1'b0, a_q[idx]} + {1'b0, b_q[idx]} + {4'b0, carry};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= S_IDLE;
         a_q         <= '0;
         b_q         <= '0;
         res_q       <= '0;
         idx         <= '0;
         carry       <= 1'b0;
         carry_out_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            S_IDLE: if (bus.start) state <= S_LOAD;
            S_LOAD: begin
               a_q   <= bus.a_in;
               b_q   <= b_load;
               carry <= bus.mode;
               idx   <= '0;
               state <= S_SUM;
            end
            S_SUM: begin
               if (t <= 5'd9) begin
                  res_q[idx] <= t[3:0];
                  carry      <= 1'b0;
                  state      <= S_NEXT;
               end else begin
                  state      <= S_CORR;
               end
            end
            S_CORR: begin
               res_q[idx] <= t[3:0] + 4'd6;
               carry      <= 1'b1;
               state      <= S_NEXT;
            end
            S_NEXT: begin
               idx   <= idx + IW'(1);
               state <= (idx == IW'(N_DIGITS - 1)) ? S_DONE : S_SUM;
            end
            S_DONE: begin
               done_q      <= 1'b1;
               carry_out_q <= carry;
               state       <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.busy      = (state != S_IDLE) && (state != S_DONE);
   assign bus.done      = done_q;
   assign bus.result    = res_q;
   assign bus.carry_out = carry_out_q;

`ifdef BCD_DIGIT_CHECK_EN
   logic err_q, bad_digit;

   always_comb begin
      bad_digit = 1'b0;
      for (int i = 0; i < N_DIGITS; i++)
         if (bus.a_in[i] > 4'd9 || bus.b_in[i] > 4'd9) bad_digit = 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                 err_q <= 1'b0;
      else if (state == S_LOAD) err_q <= bad_digit;
   end

   assign bus.err = err_q;
`else
   assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_addsub_serial.sv
// Scoreboard bench for bcd_addsub_serial: decimal model predicts result, carry and latency.
module tb_bcd_addsub_serial;
   localparam int N = 6;
   typedef logic [N-1:0][3:0] digs_t;
   typedef struct {
      digs_t res;
      logic  co;
      int    lat;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   total = 0;
   int   bad   = 0;
   exp_t sb[$];

   bcd_addsub_serial_if #(.N_DIGITS(N)) bus ();
   bcd_addsub_serial #(.N_DIGITS(N)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   function automatic digs_t to_bcd(longint v);
      digs_t d;
      for (int i = 0; i < N; i++) begin
         d[i] = 4'(v % 10);
         v    = v / 10;
      end
      return d;
   endfunction

   // Arithmetic model: correction at digit i iff the decimal prefix sum overflows.
   function automatic exp_t model(longint a, longint b, bit m);
      exp_t   e;
      longint p = 1, bp, s, q = 1;
      int     corr = 0;
      for (int i = 0; i < N; i++) p = p * 10;
      bp = m ? (p - 1 - b) : b;
      s  = a + bp + longint'(m);
      for (int i = 0; i < N; i++) begin
         q = q * 10;
         if ((a % q) + (bp % q) + longint'(m) >= q) corr++;
      end
      e.res = to_bcd(s % p);
      e.co  = (s >= p);
      e.lat = 2 * N + 2 + corr;
      return e;
   endfunction

   task automatic issue(digs_t a, digs_t b, bit m);
      @(negedge clk);
      bus.a_in  = a;
      bus.b_in  = b;
      bus.mode  = m;
      bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
   endtask

   task automatic push(longint a, longint b, bit m);
      sb.push_back(model(a, b, m));
      issue(to_bcd(a), to_bcd(b), m);
   endtask

   // Scrambles inputs after LOAD; returns latency (-1 on timeout) and busy-low sample count.
   task automatic wait_done(output digs_t res, output logic co, output logic er,
                            output int lat, output int busy_low);
      lat = -1; busy_low = 0; res = 'x; co = 1'bx; er = 1'bx;
      for (int c = 1; c <= 100; c++) begin
         @(posedge clk);
         #1;
         if (c == 1) begin
            bus.a_in = digs_t'({$urandom, $urandom});
            bus.b_in = digs_t'({$urandom, $urandom});
            bus.mode = 1'($urandom);
         end
         if (bus.done) begin
            res = bus.result; co = bus.carry_out; er = bus.err; lat = c;
            break;
         end
         if (!bus.busy) busy_low++;
      end
   endtask

   task automatic check_op(string name);
      digs_t r; logic co, er; int lat, bl;
      exp_t  e;
      wait_done(r, co, er, lat, bl);
      e = sb.pop_front();
      total += 4;
      if (r !== e.res) begin bad++; $display("FAIL %s result got=%h want=%h", name, r, e.res); end
      if (co !== e.co) begin bad++; $display("FAIL %s carry_out got=%b want=%b", name, co, e.co); end
      if (lat !== e.lat) begin bad++; $display("FAIL %s latency got=%0d want=%0d", name, lat, e.lat); end
      if (bl !== 1) begin bad++; $display("FAIL %s busy_low_cycles got=%0d want=1", name, bl); end
   endtask

   task automatic test_reset();
      #2;
      total++;
      if ({bus.busy, bus.done, bus.carry_out, bus.err, bus.result} !== '0) begin
         bad++;
         $display("FAIL reset outputs got busy=%b done=%b co=%b err=%b res=%h want all 0",
                  bus.busy, bus.done, bus.carry_out, bus.err, bus.result);
      end
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
   endtask

   task automatic test_add_zero();
      digs_t held;
      push(0, 0, 1'b0);
      check_op("add_zero");
      held = bus.result;
      @(posedge clk); #1;
      total += 2;
      if (bus.done !== 1'b0) begin bad++; $display("FAIL done_pulse got=%b want=0", bus.done); end
      if (bus.result !== held) begin bad++; $display("FAIL result_hold got=%h want=%h", bus.result, held); end
   endtask

   task automatic test_add_carry();
      push(999999, 1, 1'b0);
      check_op("add_999999_1");
   endtask

   task automatic test_sub();
      push(100, 1, 1'b1);
      check_op("sub_100_1");
      push(1, 2, 1'b1);
      check_op("sub_1_2");
      push(555555, 555555, 1'b1);
      check_op("sub_equal");
   endtask

   task automatic test_reset_abort();
      int seen = 0;
      issue(to_bcd(123456), to_bcd(654321), 1'b0);
      repeat (4) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      total++;
      if ({bus.busy, bus.done, bus.carry_out, bus.result} !== '0) begin
         bad++;
         $display("FAIL abort_reset_outputs got busy=%b done=%b co=%b res=%h want 0",
                  bus.busy, bus.done, bus.carry_out, bus.result);
      end
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      repeat (20) begin
         @(posedge clk); #1;
         if (bus.done) seen++;
      end
      total++;
      if (seen !== 0) begin bad++; $display("FAIL abort_no_done got=%0d want=0", seen); end
      push(5, 5, 1'b0);
      check_op("after_abort_5_5");
   endtask

   task automatic test_back_to_back();
      longint a, b;
      bit     m;
      for (int k = 0; k < 10; k++) begin
         a = longint'($urandom_range(0, 999999));
         b = longint'($urandom_range(0, 999999));
         m = 1'($urandom);
         push(a, b, m);
         check_op($sformatf("rand%0d", k));
      end
   endtask

   task automatic test_err();
      digs_t a, r; logic co, er; int lat, bl;
      a    = to_bcd(123456);
      a[0] = 4'hA;
      issue(a, to_bcd(1), 1'b0);
      wait_done(r, co, er, lat, bl);
      total += 2;
`ifdef BCD_DIGIT_CHECK_EN
      if (er !== 1'b1) begin bad++; $display("FAIL err_invalid got=%b want=1", er); end
`else
      if (er !== 1'b0) begin bad++; $display("FAIL err_tied got=%b want=0", er); end
`endif
      if (lat < 0) begin bad++; $display("FAIL err_op_done got=timeout want=done"); end
      push(11, 22, 1'b0);
      wait_done(r, co, er, lat, bl);
      void'(sb.pop_front());
      total += 2;
      if (er !== 1'b0) begin bad++; $display("FAIL err_clear got=%b want=0", er); end
      if (r !== to_bcd(33)) begin bad++; $display("FAIL err_next_result got=%h want=%h", r, to_bcd(33)); end
   endtask

   initial begin
      bus.start = 1'b0;
      bus.mode  = 1'b0;
      bus.a_in  = '0;
      bus.b_in  = '0;
      test_reset();
      test_add_zero();
      test_add_carry();
      test_sub();
      test_reset_abort();
      test_back_to_back();
      test_err();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/bcd_addsub_serial.md
BCD_ADDSUB_SERIAL -- requirements
Module: bcd_addsub_serial

Interface
REQ-001 SHALL have parameter N_DIGITS, default 6, number of BCD digits per operand (legal range 1..16).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  request an operation; sampled only in IDLE.
REQ-005 SHALL have port mode  input  1  0 = A+B, 1 = A-B; sampled with start.
REQ-006 SHALL have port a_in  input  [N_DIGITS][4]  operand A digits, index 0 = least significant digit.
REQ-007 SHALL have port b_in  input  [N_DIGITS][4]  operand B digits, same ordering.
REQ-008 SHALL have port busy  output  1  high in every state except IDLE and DONE.
REQ-009 SHALL have port done  output  1  one-cycle pulse, result valid.
REQ-010 SHALL have port result  output  [N_DIGITS][4]  BCD result, same ordering.
REQ-011 SHALL have port carry_out  output  1  add: decimal carry out of MSD; sub: 1 = no borrow (A>=B).
REQ-012 SHALL have port err  output  1  invalid input digit flag (see Configuration).

Function
REQ-013 SHALL implement FSM states IDLE, LOAD, SUM, CORR, NEXT, DONE.
REQ-014 IDLE -> LOAD on start=1; start ignored in all other states.
REQ-015 LOAD SHALL latch a_in, b_in and mode into internal registers, clear digit index to 0 and set carry to mode; for mode=1, each B digit SHALL be stored as its nine's complement (9-b).
REQ-016 SUM SHALL compute t = A[i]+B[i]+carry as a 5-bit value; t<=9: result[i]=t, carry=0, go NEXT; t>9: go CORR.
REQ-017 CORR SHALL write result[i]=(t+6) mod 16, set carry=1, go NEXT.
REQ-018 NEXT SHALL increment the index; index=N_DIGITS-1 before increment -> DONE, else -> SUM.
REQ-019 DONE SHALL assert done for exactly one cycle, copy carry to carry_out, then go IDLE.
REQ-020 Latency from the rising edge sampling start to the edge on which done rises SHALL be 2*N_DIGITS+2 cycles plus one cycle per digit requiring correction.
REQ-021 result and carry_out SHALL hold their values from DONE until the next LOAD; result digits SHALL update only in SUM/CORR.
REQ-022 Sub with A<B SHALL yield the ten's complement of B-A with carry_out=0.
REQ-023 Changes on a_in, b_in, mode outside LOAD SHALL NOT affect the operation in progress.

Reset
REQ-024 rst=0 SHALL immediately force state IDLE, busy=0, done=0, carry_out=0, err=0, all result digits 0, index 0, regardless of clock.
REQ-025 Reset asserted mid-operation SHALL abort it with no done pulse; the first start after rst=1 SHALL begin a fresh operation.

Configuration
REQ-026 Macro BCD_DIGIT_CHECK_EN defined: LOAD SHALL set err=1 if any a_in or b_in digit exceeds 9 (checked before complementing), else clear it; the operation still completes and err holds until the next LOAD.
REQ-027 Macro BCD_DIGIT_CHECK_EN undefined: err SHALL be tied to 0 and no check logic synthesised.

Verification
REQ-028 N=6, add 000000+000000 -> result 000000, carry_out=0, done rises 14 cycles after start edge, busy high throughout.
REQ-029 N=6, add 999999+000001 -> result 000000, carry_out=1, done at 20 cycles (six corrections).
REQ-030 N=6, sub 000100-000001 -> result 000099, carry_out=1.
REQ-031 N=6, sub 000001-000002 -> result 999999, carry_out=0.
REQ-032 Start add 123456+654321, pull rst low at cycle 5, release, start 000005+000005 -> no done for the first operation; second gives 000010, carry_out=0.
REQ-033 With BCD_DIGIT_CHECK_EN, add with a_in digit 0xA -> err=1 at DONE; next valid operation -> err=0; without the macro err stays 0.
